// File: rtl/ram_rd_prefetch.sv
// rtl/ram_rd_prefetch.sv - ram read-side prefetch with credit-limited issue and output buffer
module ram_rd_prefetch #(
    parameter int RAM_DEPTH      = 32,
    parameter int RAM_ADDR_WIDTH = 5,
    parameter int RD_WIDTH       = 32,
    parameter int RD_IND         = 4,
    parameter int OBUF_DEPTH     = 4
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst,
    input  logic                      ram_rd_ok,
    output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [RD_WIDTH-1:0]       ram_rd_data,
    output logic                      ram_rd_inc,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [RD_WIDTH-1:0]       m_data,
    output logic                      ovf_err
);

    localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int CW = $clog2(OBUF_DEPTH + 1);

    logic [RAM_ADDR_WIDTH-1:0] r_addr;
    logic                      r_inflight;
    logic [CW-1:0]             r_count;
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [RD_WIDTH-1:0]       r_buf [OBUF_DEPTH];
    logic                      r_ovf;

    logic [CW:0]               w_occ;
    logic                      w_issue;
    logic                      w_full;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_push_ok;

    // Credit check uses only registered occupancy so m_ready never reaches issue.
    assign w_occ     = {1'b0, r_count} + (CW+1)'(r_inflight);
    assign w_issue   = ram_rd_ok && !rd_rst && (w_occ < (CW+1)'(OBUF_DEPTH));
    assign w_full    = (r_count == CW'(OBUF_DEPTH));
    assign w_pop     = m_valid && m_ready;
    assign w_push    = r_inflight;
    assign w_push_ok = w_push && (!w_full || w_pop);

    assign ram_rd_addr = r_addr;
    assign ram_rd_inc  = w_issue;
    assign m_valid     = (r_count != '0);
    assign m_data      = r_buf[r_rd_ptr];
    assign ovf_err     = r_ovf;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_addr <= r_addr + RAM_ADDR_WIDTH'(RD_IND);
            end
            // The returning word lands one cycle after its issue, whether or not anyone pops.
            if (w_push_ok) begin
                r_buf[r_wr_ptr] <= ram_rd_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
